// File: rtl/addsub_op_queue.sv
// ---------------------------------------------------------------------------
// addsub_op_queue
//
// Operand-issue and result-capture stage wrapped around the external
// combinational 4-bit adder/subtractor. Incoming add/sub requests are
// buffered in a small FIFO. The head entry drives the adder/subtractor, and
// its outputs are captured into a holding register. That register offers the
// result downstream through a valid/ready handshake. A saturating counter
// tracks how many overflowed results were accepted downstream.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     request handshake (in_ready = FIFO not full)
//   in_a, in_b, in_m      operands and operation (m=1 -> A - B)
//   as_a, as_b, as_m      head entry to the adder/subtractor (0 when empty)
//   as_sum/carry/v        adder/subtractor results
//   out_valid/out_ready   result handshake
//   out_sum/carry/v/m     registered result and its operation
//   count                 FIFO occupancy
//   ovf_cnt               saturating count of accepted results with v=1
// ---------------------------------------------------------------------------
module addsub_op_queue #(
   parameter int DEPTH = 4,
   parameter int CW    = 3
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [3:0]    in_a,
   input  logic [3:0]    in_b,
   input  logic          in_m,
   output logic [3:0]    as_a,
   output logic [3:0]    as_b,
   output logic          as_m,
   input  logic [3:0]    as_sum,
   input  logic          as_carry,
   input  logic          as_v,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [3:0]    out_sum,
   output logic          out_carry,
   output logic          out_v,
   output logic          out_m,
   output logic [CW-1:0] count,
   output logic [7:0]    ovf_cnt
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   // Each entry packs {a, b, m}.
   logic [8:0]    mem_q [DEPTH];
   logic [PW-1:0] wrPtr_q, wrPtr_d;
   logic [PW-1:0] rdPtr_q, rdPtr_d;
   logic [CW-1:0] count_q, count_d;

   logic          outValid_q, outValid_d;
   logic [3:0]    outSum_q, outSum_d;
   logic          outCarry_q, outCarry_d;
   logic          outV_q, outV_d;
   logic          outM_q, outM_d;
   logic [7:0]    ovfCnt_q, ovfCnt_d;

   logic          fifoEmpty;
   logic          slotFree;
   logic          push;
   logic          pop;
   logic [8:0]    headEntry;

   // in_ready and the head drive come from registered state only, so nothing
   // combinational runs from in_valid or out_ready back to in_ready.
   assign fifoEmpty = (count_q == '0);
   assign in_ready  = (count_q < CW'(DEPTH));
   assign headEntry = mem_q[rdPtr_q];
   assign as_a      = fifoEmpty ? 4'd0 : headEntry[8:5];
   assign as_b      = fifoEmpty ? 4'd0 : headEntry[4:1];
   assign as_m      = fifoEmpty ? 1'b0 : headEntry[0];

   // The result slot can take a new value when it is empty, or when its
   // current value leaves this cycle. A full FIFO never bypasses a push,
   // because push is qualified by in_ready alone.
   assign slotFree = !outValid_q || out_ready;
   assign push     = in_valid && in_ready;
   assign pop      = !fifoEmpty && slotFree;

   // Next-state logic for the pointers, the occupancy, the result register
   // and the overflow counter. A simultaneous push and pop advances both
   // pointers and leaves the count unchanged.
   always_comb begin
      wrPtr_d    = wrPtr_q;
      rdPtr_d    = rdPtr_q;
      count_d    = count_q;
      outValid_d = outValid_q;
      outSum_d   = outSum_q;
      outCarry_d = outCarry_q;
      outV_d     = outV_q;
      outM_d     = outM_q;
      ovfCnt_d   = ovfCnt_q;

      if (push) begin
         wrPtr_d = wrPtr_q + 1'b1;
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + 1'b1;
      end
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (!push && pop) begin
         count_d = count_q - 1'b1;
      end

      if (pop) begin
         outValid_d = 1'b1;
         outSum_d   = as_sum;
         outCarry_d = as_carry;
         outV_d     = as_v;
         outM_d     = headEntry[0];
      end else if (outValid_q && out_ready) begin
         outValid_d = 1'b0;
      end

      if (outValid_q && out_ready && outV_q && (ovfCnt_q != 8'hFF)) begin
         ovfCnt_d = ovfCnt_q + 8'd1;
      end
   end

   // Control and result state registers, with a synchronous reset that also
   // discards any pending FIFO entries by clearing the pointers and count.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         count_q    <= '0;
         outValid_q <= 1'b0;
         outSum_q   <= 4'd0;
         outCarry_q <= 1'b0;
         outV_q     <= 1'b0;
         outM_q     <= 1'b0;
         ovfCnt_q   <= 8'd0;
      end else begin
         wrPtr_q    <= wrPtr_d;
         rdPtr_q    <= rdPtr_d;
         count_q    <= count_d;
         outValid_q <= outValid_d;
         outSum_q   <= outSum_d;
         outCarry_q <= outCarry_d;
         outV_q     <= outV_d;
         outM_q     <= outM_d;
         ovfCnt_q   <= ovfCnt_d;
      end
   end

   // FIFO storage. It is not reset, because the count decides what is valid.
   always_ff @(posedge clk) begin
      if (push && !rst) begin
         mem_q[wrPtr_q] <= {in_a, in_b, in_m};
      end
   end

   assign out_valid = outValid_q;
   assign out_sum   = outSum_q;
   assign out_carry = outCarry_q;
   assign out_v     = outV_q;
   assign out_m     = outM_q;
   assign count     = count_q;
   assign ovf_cnt   = ovfCnt_q;

endmodule

// File: tb/tb_addsub_op_queue.sv
// ---------------------------------------------------------------------------
// tb_addsub_op_queue
//
// Directed testbench for addsub_op_queue. A behavioural 4-bit
// adder/subtractor closes the as_* loop. Each scenario task drives requests
// and compares the outputs with hand-computed values.
// ---------------------------------------------------------------------------
module tb_addsub_op_queue;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_a;
   logic [3:0] in_b;
   logic       in_m;
   logic [3:0] as_a;
   logic [3:0] as_b;
   logic       as_m;
   logic [3:0] as_sum;
   logic       as_carry;
   logic       as_v;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_sum;
   logic       out_carry;
   logic       out_v;
   logic       out_m;
   logic [2:0] count;
   logic [7:0] ovf_cnt;

   int checks;
   int failures;

   addsub_op_queue #(.DEPTH(4), .CW(3)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_m(in_m),
      .as_a(as_a), .as_b(as_b), .as_m(as_m),
      .as_sum(as_sum), .as_carry(as_carry), .as_v(as_v),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_carry(out_carry), .out_v(out_v), .out_m(out_m),
      .count(count), .ovf_cnt(ovf_cnt)
   );

   // Behavioural stand-in for the adder/subtractor. Subtract is computed as
   // A + ~B + 1, so carry=1 means no borrow.
   logic [3:0] bEff;
   assign bEff = as_m ? ~as_b : as_b;
   assign {as_carry, as_sum} = {1'b0, as_a} + {1'b0, bEff} + {4'd0, as_m};
   assign as_v = (as_a[3] == bEff[3]) && (as_sum[3] != as_a[3]);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Global watchdog so that the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Advance one edge, then settle 1 time unit so that sampling and driving
   // stay away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setReq(input logic v, input logic [3:0] a, input logic [3:0] b, input logic m);
      in_valid = v;
      in_a     = a;
      in_b     = b;
      in_m     = m;
   endtask

   task automatic test_reset();
      rst = 1'b1; out_ready = 1'b0; setReq(1'b0, 4'd0, 4'd0, 1'b0);
      tick(); tick();
      rst = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %0b expected 0", out_valid); end
      checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
      checks++; if (ovf_cnt !== 8'd0) begin failures++; $display("[TB] FAIL reset_ovf_cnt: got %0d expected 0", ovf_cnt); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
      checks++; if (out_sum !== 4'd0) begin failures++; $display("[TB] FAIL reset_out_sum: got %0d expected 0", out_sum); end
      checks++; if ({as_a, as_b, as_m} !== 9'd0) begin failures++; $display("[TB] FAIL reset_as_empty: got %0h expected 0", {as_a, as_b, as_m}); end
   endtask

   task automatic test_add();
      setReq(1'b1, 4'd3, 4'd2, 1'b0);
      tick();
      setReq(1'b0, 4'd0, 4'd0, 1'b0);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL add_latency_early: got %0b expected 0", out_valid); end
      checks++; if ({as_a, as_b, as_m} !== {4'd3, 4'd2, 1'b0}) begin failures++; $display("[TB] FAIL add_head_drive: got %0h expected %0h", {as_a, as_b, as_m}, {4'd3, 4'd2, 1'b0}); end
      tick();
      checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL add_out_valid: got %0b expected 1", out_valid); end
      checks++; if ({out_sum, out_carry, out_v, out_m} !== {4'd5, 1'b0, 1'b0, 1'b0}) begin failures++; $display("[TB] FAIL add_result: got %0h expected %0h", {out_sum, out_carry, out_v, out_m}, {4'd5, 3'b000}); end
      checks++; if (count !== 3'd0) begin failures++; $display("[TB] FAIL add_count: got %0d expected 0", count); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL add_drain: got %0b expected 0", out_valid); end
      checks++; if (out_sum !== 4'd5) begin failures++; $display("[TB] FAIL add_hold_after_drain: got %0d expected 5", out_sum); end
   endtask

   task automatic test_overflow();
      setReq(1'b1, 4'd7, 4'd1, 1'b0);
      tick();
      setReq(1'b0, 4'd0, 4'd0, 1'b0);
      tick();
      checks++; if ({out_valid, out_sum, out_carry, out_v} !== {1'b1, 4'd8, 1'b0, 1'b1}) begin failures++; $display("[TB] FAIL ovf_result: got %0h expected %0h", {out_valid, out_sum, out_carry, out_v}, {1'b1, 4'd8, 1'b0, 1'b1}); end
      checks++; if (ovf_cnt !== 8'd0) begin failures++; $display("[TB] FAIL ovf_cnt_before_accept: got %0d expected 0", ovf_cnt); end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++; if (ovf_cnt !== 8'd1) begin failures++; $display("[TB] FAIL ovf_cnt_after_accept: got %0d expected 1", ovf_cnt); end
   endtask

   task automatic test_subtract();
      out_ready = 1'b1;
      setReq(1'b1, 4'd5, 4'd3, 1'b1);
      tick();
      setReq(1'b1, 4'd3, 4'd5, 1'b1);
      tick();
      checks++; if ({out_valid, out_sum, out_carry, out_v, out_m} !== {1'b1, 4'd2, 1'b1, 1'b0, 1'b1}) begin failures++; $display("[TB] FAIL sub_5m3: got %0h expected %0h", {out_valid, out_sum, out_carry, out_v, out_m}, {1'b1, 4'd2, 3'b101}); end
      setReq(1'b1, 4'd8, 4'd1, 1'b1);
      tick();
      setReq(1'b0, 4'd0, 4'd0, 1'b0);
      checks++; if ({out_valid, out_sum, out_carry, out_v, out_m} !== {1'b1, 4'd14, 1'b0, 1'b0, 1'b1}) begin failures++; $display("[TB] FAIL sub_3m5: got %0h expected %0h", {out_valid, out_sum, out_carry, out_v, out_m}, {1'b1, 4'd14, 3'b001}); end
      tick();
      checks++; if ({out_valid, out_sum, out_carry, out_v, out_m} !== {1'b1, 4'd7, 1'b1, 1'b1, 1'b1}) begin failures++; $display("[TB] FAIL sub_8m1: got %0h expected %0h", {out_valid, out_sum, out_carry, out_v, out_m}, {1'b1, 4'd7, 3'b111}); end
      tick();
      out_ready = 1'b0;
      checks++; if ({out_valid, ovf_cnt} !== {1'b0, 8'd2}) begin failures++; $display("[TB] FAIL sub_ovf_cnt: got %0h expected %0h", {out_valid, ovf_cnt}, {1'b0, 8'd2}); end
   endtask

   task automatic test_backpressure();
      logic [3:0] reqA [5] = '{4'd1, 4'd2, 4'd3, 4'd6, 4'd4};
      logic [3:0] reqB [5] = '{4'd1, 4'd2, 4'd3, 4'd1, 4'd5};
      logic       reqM [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [3:0] expSum [5] = '{4'd2, 4'd4, 4'd0, 4'd7, 4'd9};
      logic       expC [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic       expV [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         setReq(1'b1, reqA[i], reqB[i], reqM[i]);
         tick();
      end
      checks++; if ({in_ready, count} !== {1'b0, 3'd4}) begin failures++; $display("[TB] FAIL bp_full: got in_ready=%0b count=%0d expected in_ready=0 count=4", in_ready, count); end
      checks++; if ({out_valid, out_sum} !== {1'b1, 4'd2}) begin failures++; $display("[TB] FAIL bp_first_latched: got %0h expected %0h", {out_valid, out_sum}, {1'b1, 4'd2}); end
      // A push while full must be ignored.
      setReq(1'b1, 4'd15, 4'd15, 1'b0);
      tick();
      setReq(1'b0, 4'd0, 4'd0, 1'b0);
      checks++; if ({count, as_a, out_sum} !== {3'd4, 4'd2, 4'd2}) begin failures++; $display("[TB] FAIL bp_push_while_full: got %0h expected %0h", {count, as_a, out_sum}, {3'd4, 4'd2, 4'd2}); end
      out_ready = 1'b1;
      for (int i = 1; i < 5; i++) begin
         tick();
         checks++; if ({out_valid, out_sum, out_carry, out_v, out_m} !== {1'b1, expSum[i], expC[i], expV[i], reqM[i]}) begin failures++; $display("[TB] FAIL bp_drain_%0d: got %0h expected %0h", i, {out_valid, out_sum, out_carry, out_v, out_m}, {1'b1, expSum[i], expC[i], expV[i], reqM[i]}); end
      end
      tick();
      out_ready = 1'b0;
      checks++; if ({out_valid, count, ovf_cnt} !== {1'b0, 3'd0, 8'd3}) begin failures++; $display("[TB] FAIL bp_drain_end: got valid=%0b count=%0d ovf=%0d expected 0 0 3", out_valid, count, ovf_cnt); end
   endtask

   task automatic test_back_to_back();
      int waited;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         setReq(1'b1, 4'(i), 4'd1, 1'b0);
         tick();
      end
      checks++; if ({out_valid, count, out_sum} !== {1'b1, 3'd2, 4'd1}) begin failures++; $display("[TB] FAIL b2b_prefill: got %0h expected %0h", {out_valid, count, out_sum}, {1'b1, 3'd2, 4'd1}); end
      out_ready = 1'b1;
      // Each cycle pushes item k+2 and presents item k; item k's sum is k+1.
      for (int k = 1; k <= 10; k++) begin
         setReq(1'b1, 4'(k + 2), 4'd1, 1'b0);
         tick();
         checks++; if ({out_valid, count, out_sum} !== {1'b1, 3'd2, 4'(k + 1)}) begin failures++; $display("[TB] FAIL b2b_step_%0d: got valid=%0b count=%0d sum=%0d expected 1 2 %0d", k, out_valid, count, out_sum, k + 1); end
      end
      setReq(1'b0, 4'd0, 4'd0, 1'b0);
      waited = 0;
      while (out_valid === 1'b1 && waited < 10) begin
         tick();
         waited++;
      end
      checks++; if (out_valid !== 1'b0 || waited !== 3) begin failures++; $display("[TB] FAIL b2b_drain: got valid=%0b cycles=%0d expected 0 3", out_valid, waited); end
      out_ready = 1'b0;
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         setReq(1'b1, 4'd9, 4'(i), 1'b0);
         tick();
      end
      setReq(1'b0, 4'd0, 4'd0, 1'b0);
      checks++; if ({out_valid, count} !== {1'b1, 3'd3}) begin failures++; $display("[TB] FAIL mid_setup: got valid=%0b count=%0d expected 1 3", out_valid, count); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if ({out_valid, count, ovf_cnt, out_sum, in_ready} !== {1'b0, 3'd0, 8'd0, 4'd0, 1'b1}) begin failures++; $display("[TB] FAIL mid_reset: got valid=%0b count=%0d ovf=%0d sum=%0d rdy=%0b expected 0 0 0 0 1", out_valid, count, ovf_cnt, out_sum, in_ready); end
      setReq(1'b1, 4'd3, 4'd2, 1'b0);
      tick();
      setReq(1'b0, 4'd0, 4'd0, 1'b0);
      tick();
      checks++; if ({out_valid, out_sum, count} !== {1'b1, 4'd5, 3'd0}) begin failures++; $display("[TB] FAIL mid_after_reset: got %0h expected %0h", {out_valid, out_sum, count}, {1'b1, 4'd5, 3'd0}); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst      = 1'b1;
      out_ready = 1'b0;
      setReq(1'b0, 4'd0, 4'd0, 1'b0);
      test_reset();
      test_add();
      test_overflow();
      test_subtract();
      test_backpressure();
      test_back_to_back();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
